// File: rtl/wb_mem_slave_if.sv
// wb_mem_slave_if: Wishbone B.4 pipelined bus bundle between one master and the memory slave.
// Latency: none, wires only.
// Backpressure: stall_o from the slave holds the master's strobe; ack_o/err_o terminate in order.
interface wb_mem_slave_if #(
  parameter int ADDR_WIDTH = 16
);
  logic                  cyc_i;
  logic                  stb_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] adr_i;
  logic [1:0]            sel_i;
  logic [15:0]           dat_i;
  logic [15:0]           dat_o;
  logic                  ack_o;
  logic                  err_o;
  logic                  stall_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, err_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, err_o, stall_o
  );
endinterface

// File: rtl/wb_mem_slave.sv
// wb_mem_slave: Wishbone B.4 pipelined slave over a 2**MEM_AW x 16-bit RAM (optional SLAVE_ERR_EN).
// Latency: fixed LATENCY cycles from accept edge to ACK/ERR, strictly in order.
// Backpressure: stall_o while MAX_OUT requests are outstanding; dropping cyc_i aborts all pending responses.
module wb_mem_slave #(
  parameter int ADDR_WIDTH = 16,
  parameter int MEM_AW     = 8,
  parameter int LATENCY    = 2,
  parameter int MAX_OUT    = 1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  wb_mem_slave_if.slave   bus
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  // out_cnt always equals the number of valid stages, so it can never exceed
  // LATENCY; a limit of LATENCY therefore never needs to stall the master.
  localparam bit LIMIT_ACTIVE = (MAX_OUT < LATENCY);

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [15:0] dat;
  } rsp_t;

  logic [15:0]       mem [2**MEM_AW];
  rsp_t              stage [LATENCY];
  rsp_t              new_rsp;
  logic [CNT_W-1:0]  out_cnt;
  logic [MEM_AW-1:0] idx;
  logic              accept;
  logic              addr_err;
  logic              fin_vld;
  logic              fin_err;

  assign idx = bus.adr_i[MEM_AW-1:0];

`ifdef SLAVE_ERR_EN
  // Any upper address bit set points outside the RAM and earns an ERR.
  assign addr_err = |bus.adr_i[ADDR_WIDTH-1:MEM_AW];
`else
  // Upper address bits are don't-care: the RAM aliases across the whole space.
  logic unused_hi_adr;
  assign unused_hi_adr = ^bus.adr_i[ADDR_WIDTH-1:MEM_AW];
  assign addr_err      = 1'b0;
`endif

  // stall_o comes from registered state only, no path from stb_i.
  assign bus.stall_o = LIMIT_ACTIVE && (out_cnt == CNT_W'(MAX_OUT));
  assign accept      = bus.cyc_i & bus.stb_i & ~bus.stall_o;

  assign fin_vld = stage[LATENCY-1].vld;
  assign fin_err = stage[LATENCY-1].err;

  // Response for a request being accepted this cycle: read data sampled now,
  // so it reflects every write committed on earlier edges.
  always_comb begin
    new_rsp     = '0;
    new_rsp.vld = 1'b1;
    new_rsp.err = addr_err;
    if (!bus.we_i && !addr_err) begin
      new_rsp.dat = mem[idx];
    end
  end

  // RAM write port: byte lanes under sel_i, out-of-range writes suppressed; contents never reset.
  always_ff @(posedge clk_i) begin
    if (accept && bus.we_i && !addr_err) begin
      if (bus.sel_i[0]) mem[idx][7:0]  <= bus.dat_i[7:0];
      if (bus.sel_i[1]) mem[idx][15:8] <= bus.dat_i[15:8];
    end
  end

  // Response shift pipeline: stage 0 loads on accept, everything flushes on cycle abort.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else if (!bus.cyc_i) begin
      for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
    end else begin
      stage[0] <= accept ? new_rsp : '0;
      for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
    end
  end

  // Outstanding count: +1 per accept, -1 as the final stage retires, cleared on abort.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      out_cnt <= '0;
    end else if (!bus.cyc_i) begin
      out_cnt <= '0;
    end else begin
      case ({accept, fin_vld})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Terminations are gated by cyc_i so nothing is signalled outside a bus cycle.
  assign bus.ack_o = bus.cyc_i & fin_vld & ~fin_err;
`ifdef SLAVE_ERR_EN
  assign bus.err_o = bus.cyc_i & fin_vld & fin_err;
`else
  assign bus.err_o = 1'b0;
`endif
  assign bus.dat_o = bus.ack_o ? stage[LATENCY-1].dat : 16'h0000;

endmodule

// File: tb/tb_wb_mem_slave.sv
// tb_wb_mem_slave: directed bench for wb_mem_slave with an in-order response scoreboard.
// u0 uses the default limits (MAX_OUT=1, LATENCY=2); u1 uses MAX_OUT=LATENCY=2.
// Both share the strobe/data wires; each has its own cyc enable.
module tb_wb_mem_slave;

  typedef struct packed {
    logic        err;
    logic [15:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [15:0] adr = '0;
  logic [1:0]  sel = '0;
  logic [15:0] wdat = '0;
  logic        en0 = 1'b1;
  logic        en1 = 1'b0;

  int checks = 0;
  int failures = 0;
  int ack_cnt0 = 0;
  int ack_cnt1 = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] model [256];

  wb_mem_slave_if #(.ADDR_WIDTH(16)) bus0 ();
  wb_mem_slave_if #(.ADDR_WIDTH(16)) bus1 ();

  assign bus0.cyc_i = cyc & en0;
  assign bus0.stb_i = stb;
  assign bus0.we_i  = we;
  assign bus0.adr_i = adr;
  assign bus0.sel_i = sel;
  assign bus0.dat_i = wdat;
  assign bus1.cyc_i = cyc & en1;
  assign bus1.stb_i = stb;
  assign bus1.we_i  = we;
  assign bus1.adr_i = adr;
  assign bus1.sel_i = sel;
  assign bus1.dat_i = wdat;

  wb_mem_slave u0 (.clk_i(clk), .reset_i(rst_n), .bus(bus0));
  wb_mem_slave #(.MAX_OUT(2)) u1 (.clk_i(clk), .reset_i(rst_n), .bus(bus1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one strobe, hold it until accepted, record expectations; returns in the cycle after the accept edge.
  task automatic do_req(input logic w, input logic [15:0] a, input logic [1:0] s,
                        input logic [15:0] d, output int tries);
    exp_t e;
    logic bad;
    we = w; adr = a; sel = s; wdat = d; stb = 1'b1; tries = 0;
    while (((en0 && bus0.stall_o) || (en1 && bus1.stall_o)) && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (tries >= 20) begin
      check("req_stall_timeout", tries, 0);
      stb = 1'b0;
      return;
    end
`ifdef SLAVE_ERR_EN
    bad = (a[15:8] != 8'h00);
`else
    bad = 1'b0;
`endif
    e.err = bad;
    e.dat = (w || bad) ? 16'h0000 : model[a[7:0]];
    if (en0) q0.push_back(e);
    if (en1) q1.push_back(e);
    if (w && !bad) begin
      if (s[0]) model[a[7:0]][7:0]  = d[7:0];
      if (s[1]) model[a[7:0]][15:8] = d[15:8];
    end
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      check("idle_timeout", q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
    end
    @(negedge clk);
  endtask

  // Scoreboard for u0: every termination pops one expectation; dat_o must be 0 otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus0.ack_o || bus0.err_o) begin
        if (q0.size() == 0) begin
          check("u0_unexpected_rsp", {14'b0, bus0.err_o, bus0.ack_o, bus0.dat_o}, 0);
        end else begin
          exp_t e;
          e = q0.pop_front();
          ack_cnt0++;
          check("u0_rsp", {14'b0, bus0.err_o, bus0.ack_o, bus0.dat_o},
                {14'b0, e.err, ~e.err, e.dat});
        end
      end else begin
        check("u0_dat_idle", bus0.dat_o, 0);
      end
    end
  end

  // Scoreboard for u1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.ack_o || bus1.err_o) begin
        if (q1.size() == 0) begin
          check("u1_unexpected_rsp", {14'b0, bus1.err_o, bus1.ack_o, bus1.dat_o}, 0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          ack_cnt1++;
          check("u1_rsp", {14'b0, bus1.err_o, bus1.ack_o, bus1.dat_o},
                {14'b0, e.err, ~e.err, e.dat});
        end
      end else begin
        check("u1_dat_idle", bus1.dat_o, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    logic [5:0] pat;
    int acks_before;

    // Reset state
    #3;
    check("rst_ack",   bus0.ack_o,   0);
    check("rst_err",   bus0.err_o,   0);
    check("rst_stall", bus0.stall_o, 0);
    check("rst_dat",   bus0.dat_o,   0);
    check("rst_cnt",   u0.out_cnt,   0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 1'b1;

    // Write 0xBEEF to 0x0010: stall for two cycles, ACK in the second of them
    do_req(1'b1, 16'h0010, 2'b11, 16'hBEEF, tries);
    check("wr_first_accept", tries, 0);
    check("wr_stall_c1", bus0.stall_o, 1);
    check("wr_ack_c1",   bus0.ack_o,   0);
    @(negedge clk);
    check("wr_stall_c2", bus0.stall_o, 1);
    check("wr_ack_c2",   bus0.ack_o,   1);
    @(negedge clk);
    check("wr_stall_c3", bus0.stall_o, 0);
    check("wr_ack_c3",   bus0.ack_o,   0);
    wait_idle();

    // Read back, then upper-lane write and read merged word
    do_req(1'b0, 16'h0010, 2'b11, 16'h0000, tries);
    wait_idle();
    do_req(1'b1, 16'h0010, 2'b10, 16'h1234, tries);
    wait_idle();
    acks_before = ack_cnt0;
    do_req(1'b0, 16'h0010, 2'b01, 16'h0000, tries);
    wait_idle();
    check("lane_read_acked", ack_cnt0 - acks_before, 1);

    // Preload both slaves
    en1 = 1'b1;
    do_req(1'b1, 16'h0001, 2'b11, 16'h1111, tries);
    wait_idle();
    do_req(1'b1, 16'h0002, 2'b11, 16'h2222, tries);
    wait_idle();
    do_req(1'b1, 16'h0003, 2'b11, 16'h3333, tries);
    wait_idle();

    // Back-to-back reads on u1: no stall, three consecutive in-order ACKs
    en0 = 1'b0;
    @(negedge clk);
    pat = '0;
    acks_before = ack_cnt1;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) begin
        exp_t e;
        stb = 1'b1; we = 1'b0; sel = 2'b11; adr = 16'(k + 1);
        check("b2b_stall", bus1.stall_o, 0);
        e.err = 1'b0;
        e.dat = model[k + 1];
        q1.push_back(e);
      end else begin
        stb = 1'b0;
      end
      pat[k] = bus1.ack_o;
      @(negedge clk);
    end
    check("b2b_ack_pattern", pat, 6'b011100);
    check("b2b_ack_count", ack_cnt1 - acks_before, 3);
    wait_idle();
    en1 = 1'b0;
    en0 = 1'b1;
    @(negedge clk);

    // Cycle abort right after a read is accepted
    acks_before = ack_cnt0;
    do_req(1'b0, 16'h0001, 2'b11, 16'h0000, tries);
    cyc = 1'b0;
    q0.delete();
    @(negedge clk);
    check("abort_ack",   bus0.ack_o,   0);
    check("abort_stall", bus0.stall_o, 0);
    check("abort_cnt",   u0.out_cnt,   0);
    @(negedge clk);
    check("abort_ack2",  bus0.ack_o,   0);
    check("abort_no_rsp", ack_cnt0 - acks_before, 0);
    cyc = 1'b1;
    do_req(1'b0, 16'h0002, 2'b11, 16'h0000, tries);
    check("abort_new_accept", tries, 0);
    wait_idle();
    check("abort_new_acked", ack_cnt0 - acks_before, 1);

    // Asynchronous reset in the middle of a read
    do_req(1'b0, 16'h0003, 2'b11, 16'h0000, tries);
    check("mid_rst_pre_stall", bus0.stall_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", bus0.stall_o, 0);
    check("mid_rst_ack",   bus0.ack_o,   0);
    check("mid_rst_err",   bus0.err_o,   0);
    check("mid_rst_dat",   bus0.dat_o,   0);
    check("mid_rst_cnt",   u0.out_cnt,   0);
    q0.delete();
    acks_before = ack_cnt0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(1'b0, 16'h0010, 2'b11, 16'h0000, tries);
    check("post_rst_first_accept", tries, 0);
    wait_idle();
    repeat (3) @(negedge clk);
    check("post_rst_single_ack", ack_cnt0 - acks_before, 1);

    // Out-of-range write: ERR with the macro, alias to 0x0000 without it
    do_req(1'b1, 16'h0000, 2'b11, 16'h5555, tries);
    wait_idle();
    do_req(1'b1, 16'h0100, 2'b11, 16'hAAAA, tries);
    @(negedge clk);
`ifdef SLAVE_ERR_EN
    check("oor_err", {bus0.err_o, bus0.ack_o}, 2'b10);
`else
    check("oor_ack", {bus0.err_o, bus0.ack_o}, 2'b01);
`endif
    wait_idle();
    do_req(1'b0, 16'h0000, 2'b11, 16'h0000, tries);
    wait_idle();

    cyc = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_mem_slave.md
# wb_mem_slave

Wishbone B.4 pipelined-mode slave backed by a small 16-bit word memory. It is the responder for the pipelined bus master: it accepts one strobe per clock, answers every accepted strobe with exactly one in-order ACK after a fixed latency, and holds STALL_O high when its outstanding-request limit is reached. It serves as the IPL/boot memory model and as a reusable on-chip RAM slave on the intercon.

## Interface
- ADDR_WIDTH, 16: width of adr_i.
- MEM_AW, 8: memory address bits; depth = 2**MEM_AW words of 16 bits.
- LATENCY, 2: cycles from accept edge to ACK, legal range 1..4.
- MAX_OUT, 1: maximum accepted-but-unacknowledged requests, legal range 1..LATENCY.

Ports:
- clk_i  in  1  bus clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- cyc_i  in  1  bus cycle in progress.
- stb_i  in  1  request strobe.
- we_i  in  1  1 = write, 0 = read.
- adr_i  in  ADDR_WIDTH  word address.
- sel_i  in  2  byte lanes; [1] = dat[15:8], [0] = dat[7:0].
- dat_i  in  16  write data.
- dat_o  out  16  read data, valid while ack_o is high.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination; constant 0 unless SLAVE_ERR_EN is defined.
- stall_o  out  1  request not accepted this cycle.

## Operation
- Accept: rising edge with cyc_i & stb_i & ~stall_o.
- Write: at the accept edge, lanes with sel_i set are written to mem[adr_i[MEM_AW-1:0]]. Lanes with sel_i clear are unchanged. No data is returned; dat_o = 0 during the write ACK.
- Read: mem is read at the accept edge. Data reflects all writes accepted on earlier edges. Both sel lanes are always returned.
- Response pipeline: LATENCY stages, each holding {valid, data, err}. The stages shift every clock, and an accept loads stage 0.
- Outstanding counter out_cnt:
  - +1 on accept, −1 when the final stage is valid.
  - Both events on the same edge leave it unchanged.
- stall_o = (out_cnt == MAX_OUT). It is derived from registered state only, with no combinational path from stb_i.
- Responses are strictly in order. Every accepted request receives exactly one ACK or ERR, unless the cycle is aborted.
- Cycle abort: when cyc_i is low at a rising edge, all stage valid bits and out_cnt clear.
  - ack_o and err_o are gated with cyc_i, so neither asserts while cyc_i is low.
  - Writes already accepted remain committed.
- stb_i is ignored when cyc_i is low.
- Addresses outside the memory, i.e. upper adr_i bits nonzero:
  - Without the macro, the upper bits are ignored and the address aliases.
  - With the macro, see Configuration.

## Timing
- Reset (reset_i low, asynchronous): ack_o = 0, err_o = 0, stall_o = 0, dat_o = 0, out_cnt = 0, all stages invalid. Memory contents are not reset.
- Reset asserted mid-transaction discards all pending responses immediately. The first accept is possible on the first rising edge after reset_i is released.
- Latency: a request accepted at edge N is acknowledged in the cycle following edge N+LATENCY−1. With LATENCY=1, ack_o is high in the cycle right after the accept edge.
- With MAX_OUT = LATENCY, stall_o never asserts and throughput is one transfer per clock.
- With MAX_OUT=1 (default), the bus runs one strobe then one ACK. stall_o is high from the accept edge until the edge at which the ACK completes.
- dat_o is held at 0 whenever ack_o is low.

## Configuration
- SLAVE_ERR_EN defined:
  - An accepted request with adr_i[ADDR_WIDTH-1:MEM_AW] ≠ 0 terminates with err_o instead of ack_o, at the same latency.
  - The write is suppressed and dat_o = 0.
- SLAVE_ERR_EN undefined: err_o is tied to 0, and out-of-range addresses alias into memory.

## Test plan
- Reset release, MAX_OUT=1, LATENCY=2:
  - Write 0xBEEF to 0x0010 with sel=2'b11 -> stall_o high for 2 cycles, then a single ack_o pulse.
  - A following read of 0x0010 -> dat_o = 0xBEEF together with ack_o.
- Byte lane write of 0x12xx with sel=2'b10 to a word holding 0xBEEF -> subsequent read returns 0x12EF.
- MAX_OUT=LATENCY=2, reads strobed back-to-back to 0x0001, 0x0002, 0x0003 (preloaded 0x1111, 0x2222, 0x3333):
  - stall_o stays 0.
  - Three consecutive ACKs return 0x1111, 0x2222, 0x3333 in order.
- Read accepted, then cyc_i dropped the next cycle -> no ack_o, out_cnt = 0, stall_o = 0. A new cycle is accepted normally.
- reset_i pulsed low mid-read -> outputs go to 0 immediately, asynchronously, and no ACK follows.
- SLAVE_ERR_EN defined, write 0xAAAA to 0x0100 (MEM_AW=8):
  - Response is err_o=1 with ack_o=0.
  - A read of 0x0000 returns the unchanged previous value.
  - Without the macro, the same write aliases to 0x0000 and ACKs.
